// File: rtl/lwsw_chk_pkg.sv
// Shared constants for the load/store trace checker: FSM states, trace kinds, error causes.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lwsw_chk_pkg;

  // Checker FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_HOLD = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_PASS = 2'd2;
  localparam state_t ST_FAIL = 2'd3;

  // Expected-trace entry kinds; the reserved code terminates the trace like END
  localparam logic [1:0] KIND_END   = 2'b00;
  localparam logic [1:0] KIND_LOAD  = 2'b01;
  localparam logic [1:0] KIND_STORE = 2'b10;
  localparam logic [1:0] KIND_RSVD  = 2'b11;

  // Cause of the first error
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_KIND    = 3'd1;
  localparam logic [2:0] ERR_ADDR    = 3'd2;
  localparam logic [2:0] ERR_DATA    = 3'd3;
  localparam logic [2:0] ERR_EXTRA   = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_BOTH    = 3'd6;

  // True when the trace entry marks the end of the expected sequence
  function automatic logic kind_is_end(input logic [1:0] kind);
    return (kind == KIND_END) || (kind == KIND_RSVD);
  endfunction

endpackage

// File: rtl/lwsw_event_cmp.sv
// Compares one snooped data-memory access against the current expected trace entry.
// Latency: purely combinational, result valid in the same cycle as the strobes.
// Backpressure: none; passive observer of the memory bus.
module lwsw_event_cmp
  import lwsw_chk_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        kind_i,
  input  logic [ADDR_W-1:0] exp_addr_i,
  input  logic [DATA_W-1:0] exp_data_i,
  output logic              ok_o,
  output logic [2:0]        code_o
);

  // Priority-ordered classification: the first failing rule determines the cause
  always_comb begin
    code_o = ERR_NONE;
    if (we_i && re_i) begin
      code_o = ERR_BOTH;
    end else if (we_i || re_i) begin
      if (kind_is_end(kind_i)) begin
        code_o = ERR_EXTRA;
      end else if ((we_i && (kind_i != KIND_STORE)) || (re_i && (kind_i != KIND_LOAD))) begin
        code_o = ERR_KIND;
      end else if (addr_i != exp_addr_i) begin
        code_o = ERR_ADDR;
      end else if (we_i ? (wdata_i != exp_data_i) : (rdata_i != exp_data_i)) begin
        code_o = ERR_DATA;
      end
    end
  end

  assign ok_o = (code_o == ERR_NONE);

endmodule

// File: rtl/lwsw_trace_checker.sv
// Sequences processor reset, then checks every data-memory access in order against an expected trace.
// Latency: verdict registered one cycle after the offending access (or final quiet cycle / timeout).
// Backpressure: none; snoops the memory bus and never stalls the processor.
module lwsw_trace_checker
  import lwsw_chk_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int IDX_W        = 6,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 1000,
  parameter int QUIET_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              dut_rst,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [IDX_W-1:0]  exp_idx,
  input  logic [1:0]        exp_kind,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [IDX_W-1:0]  err_idx,
  output logic [2:0]        err_code,
  output logic [15:0]       cycle_count
);

  // RUN is entered on the edge where the hold counter has seen its last HOLD cycle
  localparam logic [31:0] HOLD_LAST = (RESET_CYCLES > 1) ? 32'(RESET_CYCLES - 1) : 32'd0;
  localparam logic [31:0] MAX_C     = 32'(MAX_CYCLES);
  localparam logic [31:0] QUIET_C   = 32'(QUIET_CYCLES);

  state_t             state_q, state_d;
  logic [15:0]        hold_q, hold_d;
  logic               dut_rst_q, dut_rst_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        cyc_q, cyc_d;
  logic [15:0]        quiet_q, quiet_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;
  logic [2:0]         err_code_q, err_code_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;

  logic               access;
  logic               at_end;
  logic               cmp_ok;
  logic [2:0]         cmp_code;
  logic [15:0]        cyc_inc;
  logic [15:0]        quiet_inc;
  logic               timeout;
  logic               quiet_hit;

  lwsw_event_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmp (
    .we_i       (mem_we),
    .re_i       (mem_re),
    .addr_i     (mem_addr),
    .wdata_i    (mem_wdata),
    .rdata_i    (mem_rdata),
    .kind_i     (exp_kind),
    .exp_addr_i (exp_addr),
    .exp_data_i (exp_data),
    .ok_o       (cmp_ok),
    .code_o     (cmp_code)
  );

  // Saturating increments and threshold tests shared by the RUN branch
  always_comb begin
    access    = mem_we || mem_re;
    at_end    = kind_is_end(exp_kind);
    cyc_inc   = (cyc_q == 16'hFFFF) ? cyc_q : (cyc_q + 16'd1);
    quiet_inc = (quiet_q == 16'hFFFF) ? quiet_q : (quiet_q + 16'd1);
    timeout   = ({16'd0, cyc_inc} >= MAX_C);
    quiet_hit = ({16'd0, quiet_inc} >= QUIET_C);
  end

  // Next-state logic: reset hold, in-order trace checking, terminal verdict
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    dut_rst_d  = dut_rst_q;
    idx_d      = idx_q;
    cyc_d      = cyc_q;
    quiet_d    = quiet_q;
    err_idx_d  = err_idx_q;
    err_code_d = err_code_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;

    case (state_q)
      ST_HOLD: begin
        if ({16'd0, hold_q} >= HOLD_LAST) begin
          state_d   = ST_RUN;
          dut_rst_d = 1'b0;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end

      ST_RUN: begin
        cyc_d = cyc_inc;
        if (access && !cmp_ok) begin
          // A failing access outranks everything, including a timeout this cycle
          state_d    = ST_FAIL;
          done_d     = 1'b1;
          fail_d     = 1'b1;
          err_code_d = cmp_code;
          err_idx_d  = idx_q;
        end else if (!access && at_end && quiet_hit) begin
          state_d = ST_PASS;
          done_d  = 1'b1;
          pass_d  = 1'b1;
          quiet_d = quiet_inc;
        end else if (timeout) begin
          // Index is not advanced so err_idx and exp_idx agree after a timeout
          state_d    = ST_FAIL;
          done_d     = 1'b1;
          fail_d     = 1'b1;
          err_code_d = ERR_TIMEOUT;
          err_idx_d  = idx_q;
        end else if (access) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (at_end) begin
          quiet_d = quiet_inc;
        end
      end

      default: begin
        // PASS and FAIL hold every register until RST
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_HOLD;
      hold_q     <= 16'd0;
      dut_rst_q  <= 1'b1;
      idx_q      <= '0;
      cyc_q      <= 16'd0;
      quiet_q    <= 16'd0;
      err_idx_q  <= '0;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      dut_rst_q  <= dut_rst_d;
      idx_q      <= idx_d;
      cyc_q      <= cyc_d;
      quiet_q    <= quiet_d;
      err_idx_q  <= err_idx_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  assign dut_rst     = dut_rst_q;
  assign exp_idx     = idx_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_idx     = err_idx_q;
  assign err_code    = err_code_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_lwsw_trace_checker.sv
// Bench for lwsw_trace_checker: directed scenario table, mid-run reset, randomized traces vs reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_lwsw_trace_checker;

  localparam int RC = 2;
  localparam int MC = 20;
  localparam int QC = 4;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dut_rst;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [5:0]  exp_idx;
  logic [1:0]  exp_kind;
  logic [31:0] exp_addr, exp_data;
  logic        done, pass, fail;
  logic [5:0]  err_idx;
  logic [2:0]  err_code;
  logic [15:0] cycle_count;

  // Expected trace table owned by the bench, plus the per-RUN-cycle access plan
  logic [1:0]  tk [64];
  logic [31:0] ta [64];
  logic [31:0] td [64];
  logic        pw [64];
  logic        pr [64];
  logic [31:0] pa [64];
  logic [31:0] pd [64];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         scen;
    logic       exp_pass;
    logic [2:0] exp_code;
    int         exp_ptr;
    int         exp_cyc;
  } vec_t;
  vec_t vecs [14];

  always #5 CLK = ~CLK;

  assign exp_kind = tk[exp_idx];
  assign exp_addr = ta[exp_idx];
  assign exp_data = td[exp_idx];

  lwsw_trace_checker #(
    .DATA_W(32), .ADDR_W(32), .IDX_W(6),
    .RESET_CYCLES(RC), .MAX_CYCLES(MC), .QUIET_CYCLES(QC)
  ) dut (
    .CLK(CLK), .RST(RST), .dut_rst(dut_rst),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .exp_idx(exp_idx), .exp_kind(exp_kind), .exp_addr(exp_addr), .exp_data(exp_data),
    .done(done), .pass(pass), .fail(fail),
    .err_idx(err_idx), .err_code(err_code), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h expected=%0h", tag, what, act, exp);
    end
  endtask

  task automatic idle();
    mem_we = 1'b0; mem_re = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_rdata = 32'h0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 64; i++) begin
      tk[i] = 2'b00; ta[i] = 32'h0; td[i] = 32'h0;
      pw[i] = 1'b0;  pr[i] = 1'b0;  pa[i] = 32'h0; pd[i] = 32'h0;
    end
  endtask

  task automatic put(input int i, input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
    tk[i] = k; ta[i] = a; td[i] = d;
  endtask

  task automatic st(input int c, input logic [31:0] a, input logic [31:0] d);
    pw[c] = 1'b1; pr[c] = 1'b0; pa[c] = a; pd[c] = d;
  endtask

  task automatic ld(input int c, input logic [31:0] a, input logic [31:0] d);
    pw[c] = 1'b0; pr[c] = 1'b1; pa[c] = a; pd[c] = d;
  endtask

  // Inactive data lanes carry junk so a compare on the wrong lane shows up
  task automatic drive(input int k);
    mem_we    = pw[k];
    mem_re    = pr[k];
    mem_addr  = pa[k];
    mem_wdata = pw[k] ? pd[k] : $urandom;
    mem_rdata = pr[k] ? pd[k] : $urandom;
  endtask

  // Reference verdict: walk the plan cycle by cycle over the expected list
  function automatic logic [2:0] classify(input int c, input int ptr);
    if (pw[c] && pr[c]) return 3'd6;
    if (tk[ptr] == 2'b00 || tk[ptr] == 2'b11) return 3'd4;
    if (pw[c] != (tk[ptr] == 2'b10)) return 3'd1;
    if (pa[c] != ta[ptr]) return 3'd2;
    if (pd[c] != td[ptr]) return 3'd3;
    return 3'd0;
  endfunction

  task automatic model(output logic m_pass, output logic [2:0] m_code, output int m_ptr, output int m_cyc);
    int ptr;
    int quiet;
    logic acc;
    logic [2:0] code;
    ptr = 0; quiet = 0; m_pass = 1'b0; m_code = 3'd0; m_ptr = 0; m_cyc = 0;
    for (int c = 0; c < 64; c++) begin
      acc = pw[c] | pr[c];
      if (acc) begin
        code = classify(c, ptr);
        if (code != 3'd0) begin
          m_code = code; m_ptr = ptr; m_cyc = c + 1;
          return;
        end
      end else if (tk[ptr] == 2'b00 || tk[ptr] == 2'b11) begin
        quiet++;
        if (quiet >= QC) begin
          m_pass = 1'b1; m_ptr = ptr; m_cyc = c + 1;
          return;
        end
      end
      if (c + 1 >= MC) begin
        m_code = 3'd5; m_ptr = ptr; m_cyc = c + 1;
        return;
      end
      if (acc) ptr++;
    end
  endtask

  // Reset the checker, verify cleared outputs and the dut_rst hold length.
  // Returns at the falling edge inside the first RUN cycle.
  task automatic do_reset(input string tag);
    int hi;
    idle();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk(tag, "rst_dut_rst", dut_rst, 1);
    chk(tag, "rst_done", {done, pass, fail}, 0);
    chk(tag, "rst_idx", exp_idx, 0);
    chk(tag, "rst_cyc", cycle_count, 0);
    chk(tag, "rst_err", {err_idx, err_code}, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    hi = 0;
    @(negedge CLK);
    while (dut_rst && hi < 10) begin
      hi++;
      @(negedge CLK);
    end
    chk(tag, "dut_rst_len", hi, RC);
  endtask

  task automatic run_and_check(input string tag, input logic ep, input logic [2:0] ec,
                               input int eptr, input int ecyc);
    int k;
    k = 0;
    while (!done && k < 40) begin
      drive(k);
      @(negedge CLK);
      k++;
    end
    idle();
    chk(tag, "latency", k, ecyc);
    chk(tag, "done", done, 1);
    chk(tag, "pass", pass, ep);
    chk(tag, "fail", fail, !ep);
    chk(tag, "err_code", err_code, ec);
    chk(tag, "err_idx", err_idx, ep ? 0 : eptr);
    chk(tag, "exp_idx", exp_idx, eptr);
    chk(tag, "cycle_count", cycle_count, ecyc);
    chk(tag, "dut_rst", dut_rst, 0);
    // Verdict must stay frozen even with bus activity afterwards
    mem_we = 1'b1; mem_re = 1'b1; mem_addr = 32'h99;
    repeat (3) @(negedge CLK);
    idle();
    chk(tag, "hold_done", done, 1);
    chk(tag, "hold_cyc", cycle_count, ecyc);
    chk(tag, "hold_code", err_code, ec);
    chk(tag, "hold_pass", pass, ep);
  endtask

  task automatic setup(input int s);
    clear_all();
    case (s)
      2:       begin put(0, 2'b10, 32'h10, DB); put(1, 2'b10, 32'h14, 32'h12345678); end
      10:      tk[0] = 2'b11;
      11, 12:  for (int i = 0; i < 30; i++) put(i, 2'b10, 32'(i * 4), 32'(i));
      13:      ;
      default: begin put(0, 2'b10, 32'h10, DB); put(1, 2'b01, 32'h10, DB); end
    endcase
    case (s)
      0:  begin st(0, 32'h10, DB); ld(1, 32'h10, DB); end
      1:  st(1, 32'h10, 32'hDEADBEEE);
      2:  begin st(0, 32'h10, DB); ld(1, 32'h14, 32'h12345678); end
      3:  begin st(0, 32'h10, DB); ld(1, 32'h14, DB); end
      4:  begin st(0, 32'h10, DB); ld(1, 32'h10, DB); st(3, 32'h10, DB); end
      6:  begin st(0, 32'h10, DB); pr[0] = 1'b1; end
      7:  begin st(0, 32'h10, DB); ld(1, 32'h10, 32'h0); end
      8:  st(0, 32'h20, DB);
      9:  begin st(0, 32'h10, DB); st(1, 32'h10, DB); end
      11: for (int i = 0; i < 20; i++) st(i, 32'(i * 4), 32'(i));
      12: begin
            for (int i = 0; i < 20; i++) st(i, 32'(i * 4), 32'(i));
            pd[19] = 32'd18;
          end
      13: st(0, 32'h10, DB);
      default: ;
    endcase
  endtask

  task automatic gen_random();
    int len;
    int c;
    int r;
    clear_all();
    len = $urandom_range(0, 5);
    for (int i = 0; i < len; i++)
      put(i, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, 32'($urandom_range(0, 7)) << 2, $urandom);
    tk[len] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    c = 0;
    for (int i = 0; i < len; i++) begin
      c += $urandom_range(0, 2);
      if (tk[i] == 2'b10) st(c, ta[i], td[i]);
      else                ld(c, ta[i], td[i]);
      r = $urandom_range(0, 9);
      case (r)
        0: begin pw[c] = !pw[c]; pr[c] = !pr[c]; end
        1: pa[c] = pa[c] ^ 32'h4;
        2: pd[c] = pd[c] ^ (32'h1 << $urandom_range(0, 31));
        3: begin pw[c] = 1'b1; pr[c] = 1'b1; end
        default: ;
      endcase
      c++;
    end
    if ($urandom_range(0, 3) == 0) begin
      c += $urandom_range(0, 5);
      st(c, 32'h40, 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       mp;
    logic [2:0] mcode;
    int         mptr;
    int         mcyc;

    //          scen pass  code  ptr cyc
    vecs[0]  = '{0,  1'b1, 3'd0, 2,  6};
    vecs[1]  = '{1,  1'b0, 3'd3, 0,  2};
    vecs[2]  = '{2,  1'b0, 3'd1, 1,  2};
    vecs[3]  = '{3,  1'b0, 3'd2, 1,  2};
    vecs[4]  = '{4,  1'b0, 3'd4, 2,  4};
    vecs[5]  = '{5,  1'b0, 3'd5, 0,  20};
    vecs[6]  = '{6,  1'b0, 3'd6, 0,  1};
    vecs[7]  = '{7,  1'b0, 3'd3, 1,  2};
    vecs[8]  = '{8,  1'b0, 3'd2, 0,  1};
    vecs[9]  = '{9,  1'b0, 3'd1, 1,  2};
    vecs[10] = '{10, 1'b1, 3'd0, 0,  4};
    vecs[11] = '{11, 1'b0, 3'd5, 19, 20};
    vecs[12] = '{12, 1'b0, 3'd3, 19, 20};
    vecs[13] = '{13, 1'b0, 3'd4, 0,  1};

    RST = 1'b1;
    idle();
    clear_all();

    for (int i = 0; i < 14; i++) begin
      setup(vecs[i].scen);
      do_reset($sformatf("vec%0d", i));
      run_and_check($sformatf("vec%0d", i), vecs[i].exp_pass, vecs[i].exp_code,
                    vecs[i].exp_ptr, vecs[i].exp_cyc);
    end

    // Mid-run reset at idx 1, then a full clean rerun
    setup(0);
    do_reset("midrst");
    drive(0);
    @(negedge CLK);
    idle();
    chk("midrst", "idx_before", exp_idx, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst", "dut_rst", dut_rst, 1);
    chk("midrst", "idx", exp_idx, 0);
    chk("midrst", "cyc", cycle_count, 0);
    chk("midrst", "verdict", {done, pass, fail}, 0);
    do_reset("midrst_re");
    run_and_check("midrst_run", 1'b1, 3'd0, 2, 6);

    // Randomized traces against the reference model
    for (int it = 0; it < 30; it++) begin
      gen_random();
      model(mp, mcode, mptr, mcyc);
      do_reset($sformatf("rnd%0d", it));
      run_and_check($sformatf("rnd%0d", it), mp, mcode, mptr, mcyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
